// File: rtl/mem_store_buffer.sv
// mem_store_buffer
//   Posted-store FIFO between the CPU coupler and the memory coupler. The CPU side
//   pushes stores; the memory side drains them from the head. Loads are checked
//   against every pending store and, when the youngest matching store is a full
//   word, its data is forwarded so the load need not wait for the drain.
//
// Ports
//   sysclk, nRESET                  clock (rising edge) / synchronous active-low reset
//   st_valid/st_addr/st_data/st_byte  store request from the CPU side
//   st_ready                        store accepted this cycle when st_valid is high
//   ld_check/ld_addr                load address presented for the hazard check
//   ld_hit                          some pending store covers the load word
//   ld_fwd_valid/ld_fwd_data        forwarded data from the youngest matching word store
//   mem_valid/mem_addr/mem_data/mem_byte  head entry offered to the memory side
//   mem_ack                         memory side consumed the head this cycle
//   count, empty, full              occupancy
module mem_store_buffer #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned FWD   = 1
) (
  input  logic                       sysclk,
  input  logic                       nRESET,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  input  logic                       st_byte,
  output logic                       st_ready,
  input  logic                       ld_check,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_hit,
  output logic                       ld_fwd_valid,
  output logic [DW-1:0]              ld_fwd_data,
  output logic                       mem_valid,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_data,
  output logic                       mem_byte,
  input  logic                       mem_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] byte_q;
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;

  logic push, pop;
  logic match_any;
  logic [PW-1:0] match_sel;
  logic [PW-1:0] scan_idx;

  // Byte offset of the load never takes part in the word match.
  logic unused_ld_lsb;
  assign unused_ld_lsb = ^ld_addr[1:0];

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Outputs are forced idle while reset is asserted, whatever the stale state holds.
  assign st_ready  = nRESET & ~full;
  assign mem_valid = nRESET & ~empty;

  assign push = st_valid & st_ready;
  assign pop  = mem_valid & mem_ack;

  assign mem_addr = addr_q[rd_ptr_q];
  assign mem_data = data_q[rd_ptr_q];
  assign mem_byte = byte_q[rd_ptr_q];

  // Walk entries oldest to youngest starting at the head; the last match seen is
  // the youngest one, which is the store a load must observe.
  always_comb begin
    match_any = 1'b0;
    match_sel = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PW'(i);
      if (valid_q[scan_idx] && (addr_q[scan_idx][AW-1:2] == ld_addr[AW-1:2])) begin
        match_any = 1'b1;
        match_sel = scan_idx;
      end
    end
  end

  assign ld_hit       = nRESET & ld_check & match_any;
  assign ld_fwd_valid = (FWD != 0) & ld_hit & ~byte_q[match_sel];
  assign ld_fwd_data  = ld_fwd_valid ? data_q[match_sel] : '0;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!nRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      count_q <= count_d;
      // Push and pop never target the same slot: that needs count 0 (no pop) or
      // count DEPTH (no push).
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
    end
  end

  // Payload needs no reset; valid_q qualifies every use.
  always_ff @(posedge sysclk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
      byte_q[wr_ptr_q] <= st_byte;
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FWD   = 1;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic          sysclk = 1'b0;
  logic          nRESET = 1'b0;
  logic          st_valid = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          st_byte = 1'b0;
  logic          st_ready;
  logic          ld_check = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hit;
  logic          ld_fwd_valid;
  logic [DW-1:0] ld_fwd_data;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_byte;
  logic          mem_ack = 1'b0;
  logic [CW-1:0] count;
  logic          empty, full;

  int tests = 0;
  int fails = 0;

  always #5 sysclk = ~sysclk;

  mem_store_buffer #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .FWD(FWD)
  ) dut (
    .sysclk      (sysclk),
    .nRESET      (nRESET),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_byte     (st_byte),
    .st_ready    (st_ready),
    .ld_check    (ld_check),
    .ld_addr     (ld_addr),
    .ld_hit      (ld_hit),
    .ld_fwd_valid(ld_fwd_valid),
    .ld_fwd_data (ld_fwd_data),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_byte    (mem_byte),
    .mem_ack     (mem_ack),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of pending stores, oldest at index 0.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          b;
  } ent_t;
  ent_t q[$];

  always begin : compare
    bit exp_hit, exp_fv, found;
    logic [DW-1:0] exp_fd;
    bit do_push, do_pop;
    @(posedge sysclk);
    q.delete();
    forever begin
      @(negedge sysclk);
      chk("count", 64'(count), 64'(q.size()));
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("full", 64'(full), 64'(q.size() == DEPTH));
      if (!nRESET) begin
        chk("rst_st_ready", 64'(st_ready), 64'(0));
        chk("rst_mem_valid", 64'(mem_valid), 64'(0));
        chk("rst_ld_hit", 64'(ld_hit), 64'(0));
        chk("rst_ld_fwd_valid", 64'(ld_fwd_valid), 64'(0));
      end else begin
        chk("st_ready", 64'(st_ready), 64'(q.size() < DEPTH));
        chk("mem_valid", 64'(mem_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
          chk("mem_addr", 64'(mem_addr), 64'(q[0].a));
          chk("mem_data", 64'(mem_data), 64'(q[0].d));
          chk("mem_byte", 64'(mem_byte), 64'(q[0].b));
        end
        found = 0;
        exp_fv = 0;
        exp_fd = '0;
        for (int j = q.size() - 1; j >= 0; j--) begin
          if (!found && (q[j].a >> 2) == (ld_addr >> 2)) begin
            found = 1;
            if (FWD != 0 && !q[j].b) begin
              exp_fv = 1;
              exp_fd = q[j].d;
            end
          end
        end
        exp_hit = ld_check && found;
        if (!exp_hit) begin
          exp_fv = 0;
          exp_fd = '0;
        end
        chk("ld_hit", 64'(ld_hit), 64'(exp_hit));
        chk("ld_fwd_valid", 64'(ld_fwd_valid), 64'(exp_fv));
        chk("ld_fwd_data", 64'(ld_fwd_data), 64'(exp_fd));
      end
      @(posedge sysclk);
      if (!nRESET) begin
        q.delete();
      end else begin
        do_push = st_valid && (q.size() < DEPTH);
        do_pop  = mem_ack && (q.size() > 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back('{a: st_addr, d: st_data, b: st_byte});
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_st(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit b);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_byte  = b;
  endtask

  initial begin
    // 1: reset, fill to full, fifth push ignored
    tick();
    tick();
    nRESET = 1'b1;
    #1;
    chk("t1_count_rst", 64'(count), 64'(0));
    chk("t1_empty_rst", 64'(empty), 64'(1));
    chk("t1_full_rst", 64'(full), 64'(0));
    for (int i = 0; i < 4; i++) begin
      set_st(1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 0);
      tick();
    end
    set_st(1, 32'h110, 32'hDEAD_BEEF, 0);
    #1;
    chk("t1_count4", 64'(count), 64'(4));
    chk("t1_full", 64'(full), 64'(1));
    chk("t1_st_ready", 64'(st_ready), 64'(0));
    tick();
    set_st(0, '0, '0, 0);
    #1;
    chk("t1_fifth_ignored", 64'(count), 64'(4));

    // 2: drain in order
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_mem_addr", 64'(mem_addr), 64'(32'h100 + 32'(4 * i)));
      tick();
    end
    mem_ack = 1'b0;
    #1;
    chk("t2_empty", 64'(empty), 64'(1));
    chk("t2_mem_valid", 64'(mem_valid), 64'(0));

    // 3: youngest word store forwards
    set_st(1, 32'h200, 32'hAAAA_5555, 0);
    tick();
    set_st(1, 32'h200, 32'h1234_5678, 0);
    tick();
    set_st(0, '0, '0, 0);
    ld_check = 1'b1;
    ld_addr  = 32'h202;
    #1;
    chk("t3_hit", 64'(ld_hit), 64'(1));
    chk("t3_fwd_valid", 64'(ld_fwd_valid), 64'(1));
    chk("t3_fwd_data", 64'(ld_fwd_data), 64'(32'h1234_5678));
    ld_check = 1'b0;
    mem_ack  = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;

    // 4: byte store hits but does not forward
    set_st(1, 32'h301, 32'h77, 1);
    tick();
    set_st(0, '0, '0, 0);
    ld_check = 1'b1;
    ld_addr  = 32'h300;
    #1;
    chk("t4_hit", 64'(ld_hit), 64'(1));
    chk("t4_fwd_valid", 64'(ld_fwd_valid), 64'(0));
    chk("t4_mem_byte", 64'(mem_byte), 64'(1));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("t4_hit_cleared", 64'(ld_hit), 64'(0));
    ld_check = 1'b0;

    // 5: steady push+pop across pointer wrap
    set_st(1, 32'h400, 32'h4000, 0);
    tick();
    set_st(1, 32'h404, 32'h4004, 0);
    tick();
    mem_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_st(1, 32'h408 + 32'(4 * k), 32'h4008 + 32'(4 * k), 0);
      #1;
      chk("t5_count", 64'(count), 64'(2));
      chk("t5_order", 64'(mem_addr), 64'(32'h400 + 32'(4 * k)));
      tick();
    end
    set_st(0, '0, '0, 0);
    tick();
    tick();
    mem_ack = 1'b0;
    #1;
    chk("t5_empty", 64'(empty), 64'(1));

    // 6: reset mid-drain
    for (int i = 0; i < 3; i++) begin
      set_st(1, 32'h500 + 32'(4 * i), 32'h5000 + 32'(i), 0);
      tick();
    end
    set_st(0, '0, '0, 0);
    mem_ack = 1'b1;
    tick();
    nRESET   = 1'b0;
    ld_check = 1'b1;
    ld_addr  = 32'h504;
    #1;
    chk("t6_rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("t6_rst_ld_hit", 64'(ld_hit), 64'(0));
    tick();
    nRESET = 1'b1;
    #1;
    chk("t6_count", 64'(count), 64'(0));
    chk("t6_mem_valid", 64'(mem_valid), 64'(0));
    chk("t6_ld_hit", 64'(ld_hit), 64'(0));
    mem_ack  = 1'b0;
    ld_check = 1'b0;
    set_st(1, 32'h600, 32'h6000, 0);
    tick();
    set_st(0, '0, '0, 0);
    #1;
    chk("t6_resume_valid", 64'(mem_valid), 64'(1));
    chk("t6_resume_addr", 64'(mem_addr), 64'(32'h600));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;

    // Random phase: small address pool so hits and forwarding are frequent.
    for (int n = 0; n < 3000; n++) begin
      nRESET   = ($urandom_range(63) != 0);
      st_valid = $urandom_range(2) != 0;
      st_addr  = 32'h0000_0800 | 32'($urandom_range(15));
      st_data  = $urandom;
      st_byte  = $urandom_range(3) == 0;
      mem_ack  = $urandom_range(2) == 0;
      ld_check = $urandom_range(1) != 0;
      ld_addr  = 32'h0000_0800 | 32'($urandom_range(19));
      tick();
    end
    nRESET   = 1'b1;
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    ld_check = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
